mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//   Memory bus controller between core load/store port and data memory. Decodes each request:
//   word addrs 0x0000-0x003F go to the mapped-register block (single-cycle, 2-bit sub-decode
//   done there); all others go to external async SRAM with a timed CE/OE/WE sequence.
//   Returns read data and a one-cycle ack to the core; one transaction outstanding at a time.
// PARAMETERS
//   SRAM_WAIT  2  cycles OE_n/WE_n held low per SRAM access; legal range 1..15 (elab check)
//   MMR_BITS   6  low addr bits spanned by mapped-register region (region = addr[13:MMR_BITS]==0)
// PORTS
//   i_clk          in   1   system clock, all state on rising edge
//   i_rstn         in   1   reset, asynchronous, active-low
//   i_coreReq      in   1   core request; sampled only in IDLE
//   i_coreWr       in   1   1=write, 0=read; sampled with i_coreReq
//   i_coreAddr     in   14  word address
//   i_coreData     in   16  write data
//   o_coreData     out  16  read data; valid in ack cycle, held until next read completes
//   o_coreAck      out  1   one-cycle completion pulse
//   o_coreBusy     out  1   high whenever state != IDLE
//   o_mmrAddr      out  14  address to mapped registers (latched copy)
//   o_mmrDataIn    out  16  write data to mapped registers
//   o_mmrWrEn      out  1   mapped-register write strobe
//   i_mmrDataOut   in   16  mapped-register read data (combinational from addr)
//   o_sramAddr     out  14  SRAM address (latched copy)
//   o_sramCEn      out  1   SRAM chip enable, active-low
//   o_sramOEn      out  1   SRAM output enable, active-low
//   o_sramWEn      out  1   SRAM write enable, active-low
//   io_sramData    inout 16 SRAM data; driven only on writes in SETUP/ACCESS/HOLD, else Z
// BEHAVIOUR
//   Reset (async): state IDLE; o_coreAck/o_mmrWrEn=0; o_coreData, addr/data latches=0;
//     o_sramCEn/OEn/WEn=1; io_sramData=Z. Mid-transaction reset aborts at once, strobes release.
//   States: IDLE, MMR, SETUP, ACCESS, HOLD, ACK. Edge E0 = edge accepting request.
//   IDLE: i_coreReq=1 -> latch wr/addr/data; addr[13:MMR_BITS]==0 ? MMR : SETUP (cnt=SRAM_WAIT).
//   MMR (1 cycle): o_mmrWrEn=wr; read captures i_mmrDataOut into o_coreData at exit edge -> ACK.
//   SETUP (1 cycle): CEn=0, OEn=WEn=1, addr stable; write drives io_sramData -> ACCESS.
//   ACCESS (SRAM_WAIT cycles): CEn=0, OEn=~rd / WEn=~wr; cnt decrements; read captures
//     io_sramData on last ACCESS edge (cnt==1) -> HOLD.
//   HOLD (1 cycle): CEn=0, OEn=WEn=1, write data still driven (hold time) -> ACK.
//   ACK (1 cycle): o_coreAck=1 -> IDLE. Write leaves o_coreData unchanged.
//   Latency: MMR ack in cycle 2 after E0; SRAM ack in cycle SRAM_WAIT+3 after E0.
//   Handshake: core holds req/wr/addr/data until ack, drops req the cycle after; req high in
//     IDLE after ACK is a new transaction. Req changes while busy are ignored (latched copy).
//   o_mmrWrEn and SRAM strobes are mutually exclusive; never both regions touched per request.
//   Strobes/o_mmrWrEn are registered outputs (glitch-free); o_coreBusy may be combinational.
//   Counter width 4 bits; cnt never wraps (exit at 1). Addr 0x003F -> MMR, 0x0040 -> SRAM.
//   Bus turnaround: io_sramData driven only when OEn=1, so no contention on read->write.
// STRUCTURE
//   Shared include MemBusDefs.vh: state encodings (3-bit), MMR_BITS default, SRAM_WAIT limits.
//   No sub-module required; FSM + wait counter + latches in one file. MappedRegisters attaches
//   to o_mmr*/i_mmrDataOut unchanged (its write enable gated here, decode stays there).
// TESTING
//   Rd 0x0005 (i_mmrDataOut=0xBEEF) -> ack cycle 2, o_coreData=0xBEEF, no SRAM strobe low.
//   Wr 0x0010 data 0x1234 -> o_mmrWrEn high exactly 1 cycle, o_mmrAddr=0x0010, ack cycle 2.
//   Wr 0x0040 data 0xA5A5, SRAM_WAIT=2 -> WEn low cycles 2-3, data driven cycles 1-4, ack cycle 5.
//   Rd 0x3FFF (model returns 0x5A5A), SRAM_WAIT=3 -> OEn low 3 cycles, data 0x5A5A, ack cycle 6.
//   Back-to-back: req held high after ack -> second txn accepted in IDLE cycle, no lost ack.
//   i_rstn low during ACCESS -> CEn/WEn=1 and io_sramData=Z same cycle, busy=0, no ack.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the memory bus controller: FSM state encoding,
// bus widths, wait-count limits and the region/phase decode helpers.
package mem_bus_ctrl_pkg;

  localparam int unsigned AddrW           = 14;
  localparam int unsigned DataW           = 16;
  localparam int unsigned CntW            = 4;
  localparam int unsigned SramWaitMin     = 1;
  localparam int unsigned SramWaitMax     = 15;
  localparam int unsigned SramWaitDefault = 2;
  localparam int unsigned MmrBitsDefault  = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMmr    = 3'd1,
    StSetup  = 3'd2,
    StAccess = 3'd3,
    StHold   = 3'd4,
    StAck    = 3'd5
  } state_e;

  // Mapped-register region is every address whose bits above mmr_bits are all zero.
  function automatic logic in_mmr_region(input logic [AddrW-1:0] addr,
                                         input int unsigned mmr_bits);
    return (addr >> mmr_bits) == '0;
  endfunction

  // States in which the SRAM chip is selected.
  function automatic logic sram_phase(input state_e st);
    return (st == StSetup) || (st == StAccess) || (st == StHold);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: routes one core load/store at a time either to the mapped
// registers (single cycle) or to an async SRAM with a timed CE/OE/WE sequence.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = SramWaitDefault,
  parameter int unsigned MMR_BITS  = MmrBitsDefault
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_coreReq,
  input  logic                 i_coreWr,
  input  logic [AddrW-1:0]     i_coreAddr,
  input  logic [DataW-1:0]     i_coreData,
  output logic [DataW-1:0]     o_coreData,
  output logic                 o_coreAck,
  output logic                 o_coreBusy,
  output logic [AddrW-1:0]     o_mmrAddr,
  output logic [DataW-1:0]     o_mmrDataIn,
  output logic                 o_mmrWrEn,
  input  logic [DataW-1:0]     i_mmrDataOut,
  output logic [AddrW-1:0]     o_sramAddr,
  output logic                 o_sramCEn,
  output logic                 o_sramOEn,
  output logic                 o_sramWEn,
  inout  wire  [DataW-1:0]     io_sramData
);

  if (SRAM_WAIT < SramWaitMin || SRAM_WAIT > SramWaitMax) begin : gen_bad_wait
    $error("mem_bus_ctrl: SRAM_WAIT must be in 1..15");
  end
  if (MMR_BITS >= AddrW) begin : gen_bad_mmr_bits
    $error("mem_bus_ctrl: MMR_BITS must be below the address width");
  end

  localparam logic [CntW-1:0] WaitLoad = CntW'(SRAM_WAIT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [DataW-1:0]  rdata_q, rdata_d;

  logic ack_q, ack_d;
  logic mmr_we_q, mmr_we_d;
  logic cen_q, cen_d;
  logic oen_q, oen_d;
  logic wen_q, wen_d;
  logic drive_q, drive_d;

  // State register plus request latches and registered strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      mmr_we_q <= 1'b0;
      cen_q    <= 1'b1;
      oen_q    <= 1'b1;
      wen_q    <= 1'b1;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      mmr_we_q <= mmr_we_d;
      cen_q    <= cen_d;
      oen_q    <= oen_d;
      wen_q    <= wen_d;
      drive_q  <= drive_d;
    end
  end

  // Next state, wait counter and data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_coreReq) begin
          wr_d    = i_coreWr;
          addr_d  = i_coreAddr;
          wdata_d = i_coreData;
          if (in_mmr_region(i_coreAddr, MMR_BITS)) begin
            state_d = StMmr;
          end else begin
            state_d = StSetup;
            cnt_d   = WaitLoad;
          end
        end
      end
      StMmr: begin
        if (!wr_q) rdata_d = i_mmrDataOut;
        state_d = StAck;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // Counter exits at 1 so it never wraps; read data is sampled on that last edge.
        if (cnt_q == 4'd1) begin
          if (!wr_q) rdata_d = io_sramData;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    ack_d    = (state_d == StAck);
    mmr_we_d = (state_d == StMmr) && wr_d;
    cen_d    = !sram_phase(state_d);
    oen_d    = !((state_d == StAccess) && !wr_d);
    wen_d    = !((state_d == StAccess) && wr_d);
    // Only writes drive the bus, and OEn stays high for writes: no turnaround contention.
    drive_d  = sram_phase(state_d) && wr_d;
  end

  assign io_sramData = drive_q ? wdata_q : {DataW{1'bz}};

  assign o_coreData  = rdata_q;
  assign o_coreAck   = ack_q;
  assign o_coreBusy  = (state_q != StIdle);
  assign o_mmrAddr   = addr_q;
  assign o_mmrDataIn = wdata_q;
  assign o_mmrWrEn   = mmr_we_q;
  assign o_sramAddr  = addr_q;
  assign o_sramCEn   = cen_q;
  assign o_sramOEn   = oen_q;
  assign o_sramWEn   = wen_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed and random transactions against a transaction-level
// model of latency, strobe windows and memory contents.
module tb_mem_bus_ctrl;

  localparam int unsigned W = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [13:0] addr = '0;
  logic [15:0] wdata = '0;

  logic [15:0] core_rd;
  logic        ack, busy;
  logic [13:0] mmr_addr, sram_addr;
  logic [15:0] mmr_din, mmr_rd;
  logic        mmr_we, sram_cen, sram_oen, sram_wen;
  wire  [15:0] io_sramData;

  logic [15:0] sram_dev [16384];
  logic [15:0] ref_mem  [16384];
  logic [15:0] mmr_dev  [4];
  logic [15:0] mmr_ref  [4];
  logic [15:0] exp_rd;

  int n_vec = 0;
  int n_bad = 0;

  mem_bus_ctrl #(.SRAM_WAIT(W), .MMR_BITS(6)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_coreReq    (req),
    .i_coreWr     (wr),
    .i_coreAddr   (addr),
    .i_coreData   (wdata),
    .o_coreData   (core_rd),
    .o_coreAck    (ack),
    .o_coreBusy   (busy),
    .o_mmrAddr    (mmr_addr),
    .o_mmrDataIn  (mmr_din),
    .o_mmrWrEn    (mmr_we),
    .i_mmrDataOut (mmr_rd),
    .o_sramAddr   (sram_addr),
    .o_sramCEn    (sram_cen),
    .o_sramOEn    (sram_oen),
    .o_sramWEn    (sram_wen),
    .io_sramData  (io_sramData)
  );

  always #5 clk = ~clk;

  // Undriven bus floats to all ones.
  pullup (io_sramData);
  assign io_sramData = (!sram_cen && !sram_oen) ? sram_dev[sram_addr] : 16'hzzzz;
  always @(posedge sram_wen) sram_dev[sram_addr] = io_sramData;

  assign mmr_rd = mmr_dev[mmr_addr[1:0]];
  always @(posedge clk) if (mmr_we) mmr_dev[mmr_addr[1:0]] = mmr_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int c = lo; c <= hi; c++) m[c] = 1'b1;
    return m;
  endfunction

  // One core transaction; entered and left at 1 time unit after a rising edge.
  task automatic txn(input logic t_wr, input logic [13:0] t_addr, input logic [15:0] t_data,
                     input logic keep, input logic perturb, input string tag);
    logic        is_mmr;
    int          exp_ack, ack_at;
    logic [31:0] m_cen, m_oen, m_wen, m_mwe, m_drv;
    is_mmr  = (t_addr < 14'd64);
    exp_ack = is_mmr ? 2 : int'(W) + 3;
    req = 1'b1; wr = t_wr; addr = t_addr; wdata = t_data;
    if (busy) begin
      @(posedge clk); #1;
      chk({tag, ":prev_ack_one_cycle"}, 32'(ack), 32'd0);
      chk({tag, ":idle_between"}, 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, ":busy"}, 32'(busy), 32'd1);
    chk({tag, ":addr_latch"}, 32'(is_mmr ? mmr_addr : sram_addr), 32'(t_addr));
    if (is_mmr && t_wr) chk({tag, ":mmr_din"}, 32'(mmr_din), 32'(t_data));
    if (perturb) begin
      addr = ~t_addr; wdata = ~t_data; wr = ~t_wr;
    end
    ack_at = 0;
    m_cen = '0; m_oen = '0; m_wen = '0; m_mwe = '0; m_drv = '0;
    for (int c = 1; c <= 30 && ack_at == 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      m_cen[c] = !sram_cen;
      m_oen[c] = !sram_oen;
      m_wen[c] = !sram_wen;
      m_mwe[c] = mmr_we;
      m_drv[c] = t_wr && (io_sramData === t_data);
      if (ack) ack_at = c;
    end
    chk({tag, ":ack_cycle"}, 32'(ack_at), 32'(exp_ack));
    if (is_mmr) begin
      chk({tag, ":cen"}, m_cen, 32'd0);
      chk({tag, ":oen"}, m_oen, 32'd0);
      chk({tag, ":wen"}, m_wen, 32'd0);
      chk({tag, ":mmr_we"}, m_mwe, t_wr ? span(1, 1) : 32'd0);
    end else begin
      chk({tag, ":cen"}, m_cen, span(1, int'(W) + 2));
      chk({tag, ":oen"}, m_oen, t_wr ? 32'd0 : span(2, int'(W) + 1));
      chk({tag, ":wen"}, m_wen, t_wr ? span(2, int'(W) + 1) : 32'd0);
      chk({tag, ":mmr_we"}, m_mwe, 32'd0);
    end
    if (t_wr) begin
      chk({tag, ":drive"}, m_drv, is_mmr ? 32'd0 : span(1, int'(W) + 2));
      if (is_mmr) mmr_ref[t_addr[1:0]] = t_data;
      else        ref_mem[t_addr] = t_data;
    end else begin
      exp_rd = is_mmr ? mmr_ref[t_addr[1:0]] : ref_mem[t_addr];
    end
    chk({tag, ":core_data"}, 32'(core_rd), 32'(exp_rd));
    if (!keep) begin
      req = 1'b0;
      @(posedge clk); #1;
      chk({tag, ":ack_one_cycle"}, 32'(ack), 32'd0);
      chk({tag, ":idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [13:0] ra;
    logic [15:0] rd;
    int          acks;
    for (int i = 0; i < 16384; i++) begin
      v = 16'(i * 40503) ^ 16'h1357;
      sram_dev[i] = v;
      ref_mem[i]  = v;
    end
    sram_dev[16383] = 16'h5A5A;
    ref_mem[16383]  = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      mmr_dev[i] = 16'(i) * 16'h1111;
      mmr_ref[i] = 16'(i) * 16'h1111;
    end
    mmr_dev[1] = 16'hBEEF;
    mmr_ref[1] = 16'hBEEF;
    exp_rd = 16'h0000;

    #12;
    chk("rst:ack", 32'(ack), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:cen", 32'(sram_cen), 32'd1);
    chk("rst:oen", 32'(sram_oen), 32'd1);
    chk("rst:wen", 32'(sram_wen), 32'd1);
    chk("rst:bus_float", 32'(io_sramData), 32'h0000FFFF);
    chk("rst:core_data", 32'(core_rd), 32'd0);
    chk("rst:mmr_we", 32'(mmr_we), 32'd0);
    chk("rst:addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    txn(1'b0, 14'h0005, 16'h0000, 1'b0, 1'b0, "mmr_rd_0005");
    txn(1'b1, 14'h0010, 16'h1234, 1'b0, 1'b0, "mmr_wr_0010");
    txn(1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, "mmr_rd_0010");
    txn(1'b1, 14'h0040, 16'hA5A5, 1'b0, 1'b0, "sram_wr_0040");
    txn(1'b0, 14'h0040, 16'h0000, 1'b0, 1'b0, "sram_rd_0040");
    txn(1'b0, 14'h3FFF, 16'h0000, 1'b0, 1'b0, "sram_rd_3fff");
    txn(1'b1, 14'h003F, 16'h0C3F, 1'b0, 1'b0, "mmr_wr_003f");
    txn(1'b0, 14'h003F, 16'h0000, 1'b0, 1'b1, "mmr_rd_003f");
    txn(1'b1, 14'h0020, 16'h7777, 1'b1, 1'b0, "b2b_wr");
    txn(1'b0, 14'h0100, 16'h0000, 1'b1, 1'b0, "b2b_rd_sram");
    txn(1'b0, 14'h0020, 16'h0000, 1'b0, 1'b0, "b2b_rd_mmr");

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 63))
                                       : 14'($urandom_range(64, 16383));
      if (ra == 14'h2AAA) ra = 14'h2AAB;
      rd = 16'($urandom);
      if (rd == 16'hFFFF) rd = 16'hFFFE;
      txn(1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Reset asserted in the middle of an SRAM write.
    req = 1'b1; wr = 1'b1; addr = 14'h2AAA; wdata = 16'h0F0F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort:wen_pre", 32'(sram_wen), 32'd0);
    rstn = 1'b0;
    #1;
    chk("abort:cen", 32'(sram_cen), 32'd1);
    chk("abort:wen", 32'(sram_wen), 32'd1);
    chk("abort:bus_float", 32'(io_sramData), 32'h0000FFFF);
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:ack", 32'(ack), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("abort:no_ack", 32'(acks), 32'd0);
    exp_rd = 16'h0000;
    chk("abort:core_data", 32'(core_rd), 32'(exp_rd));
    txn(1'b0, 14'h0005, 16'h0000, 1'b0, 1'b0, "post_abort_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
